// File: rtl/alu_control_seq_if.sv
// alu_control_seq_if: issue/consumer handshake bundle for alu_control_seq
// master: issue stage + consumer side (drives flush, in_valid, ALU_op, Funct, out_ready)
// slave:  the decoder (drives in_ready, out_valid, ALU_control, illegal, busy)
interface alu_control_seq_if #(
   parameter int OP_W   = 2,
   parameter int CTRL_W = 4
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   ALU_op;
   logic [5:0]        Funct;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] ALU_control;
   logic              illegal;
   logic              busy;
   modport master (
      output flush, in_valid, ALU_op, Funct, out_ready,
      input  in_ready, out_valid, ALU_control, illegal, busy
   );
   modport slave (
      input  flush, in_valid, ALU_op, Funct, out_ready,
      output in_ready, out_valid, ALU_control, illegal, busy
   );
endinterface

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered, handshaked ALU control decoder with multi-cycle mult/div sequencing
// clk, rst: clock and synchronous active-high reset
// bus (slave): flush, in_valid/in_ready + ALU_op/Funct in, out_valid/out_ready + ALU_control/illegal out, busy
module alu_control_seq #(
   parameter int OP_W          = 2,
   parameter int CTRL_W        = 4,
   parameter int MULDIV_CYCLES = 4,
   parameter bit ENABLE_MULDIV = 1
) (
   input logic               clk,
   input logic               rst,
   alu_control_seq_if.slave  bus
);
   localparam int CNT_W = $clog2(MULDIV_CYCLES) + 1;
   typedef enum logic [1:0] {IDLE, MULTI, OUT} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       code;
   logic             bad;
   logic             multi;
   always_comb begin
      code  = 4'd0;
      bad   = 1'b0;
      multi = 1'b0;
      case (bus.ALU_op[1:0])
         2'b01: code = 4'd1;
         2'b11: code = 4'd3;
         2'b10:
            case (bus.Funct)
               6'b100000: code = 4'd0;
               6'b100010: code = 4'd1;
               6'b100100: code = 4'd2;
               6'b100101: code = 4'd3;
               6'b000000: code = 4'd4;
               6'b000010: code = 4'd5;
               6'b101010: code = 4'd6;
               6'b100111: code = 4'd7;
               6'b011000: begin code = ENABLE_MULDIV ? 4'd8 : 4'd0; multi = ENABLE_MULDIV; bad = !ENABLE_MULDIV; end
               6'b011010: begin code = ENABLE_MULDIV ? 4'd9 : 4'd0; multi = ENABLE_MULDIV; bad = !ENABLE_MULDIV; end
               default:   bad = 1'b1;
            endcase
         default: code = 4'd0;
      endcase
   end
   // a held result frees the block only when the consumer takes it this cycle
   assign bus.in_ready = (state == IDLE) || (state == OUT && bus.out_ready);
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.ALU_control <= '0;
         bus.out_valid   <= 1'b0;
         bus.illegal     <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         case (state)
            IDLE, OUT:
               if (bus.in_ready) begin
                  if (bus.in_valid) begin
                     bus.ALU_control <= CTRL_W'(code);
                     bus.illegal     <= bad;
                     bus.out_valid   <= !multi;
                     bus.busy        <= multi;
                     cnt             <= CNT_W'(MULDIV_CYCLES - 1);
                     state           <= multi ? MULTI : OUT;
                  end else begin
                     bus.out_valid <= 1'b0;
                     state         <= IDLE;
                  end
               end
            MULTI:
               if (cnt == '0) begin
                  bus.busy      <= 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= OUT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
